ss_rob_retire: RTL and testbench
================================

// Module: ss_rob_retire
// PURPOSE
//  In-order reorder buffer (ROB) for the superscalar pipeline.
//  - Accepts up to `WIDTH dispatched instructions per cycle; records each entry's
//    arch dest, new PRF tag and previous PRF tag (Told).
//  - Marks entries complete from the complete/CDB stage.
//  - Retires up to `WIDTH completed entries per cycle from the head.
//  - Drives the retire-side write interface of the retirement RAT and returns Told to
//    the freelist. Requests a full rollback when a mispredicted branch retires.
// PARAMETERS
//  ROB_SIZE  32  entries; power of two, >= 2*`WIDTH
//  `WIDTH    global macro: superscalar width (lanes)
//  `RF_SIZE  global macro: architectural register count
//  `PRF_SIZE global macro: physical register count
// PORTS
//  clock               in   1                  clock
//  reset               in   1                  synchronous, active-high
//  dispatch_en         in   [W]                lane valid; lanes packed from lane 0
//  dispatch_has_dest   in   [W]                instr writes a register (dest != x0)
//  dispatch_dest       in   [W][log2 RF]       arch destination
//  dispatch_tag        in   [W][log2 PRF]      newly allocated PRF tag
//  dispatch_told       in   [W][log2 PRF]      previous mapping of dest
//  dispatch_idx        out  [W][log2 ROB]      ROB index given to each lane (tail+h)
//  free_slots          out  [log2 ROB:0]       ROB_SIZE - count (registered state)
//  complete_en         in   [W]                completion valid
//  complete_idx        in   [W][log2 ROB]      ROB index completing
//  complete_mispredict in   [W]                completing branch was mispredicted
//  retire_valid        out  [W]                lane retires an entry this cycle
//  retire_en           out  [W]                retire_valid & has_dest (RRAT write)
//  retire_dest         out  [W][log2 RF]       arch dest to RRAT
//  P_value             out  [W][log2 PRF]      committed PRF tag to RRAT
//  retire_told         out  [W][log2 PRF]      Told to freelist; valid with retire_en
//  rollback            out  1                  mispredicted branch retiring this cycle
// BEHAVIOUR
//  - Storage: circular buffer; head and tail indices mod ROB_SIZE; count 0..ROB_SIZE.
//    Per entry: valid, complete, mispredict, has_dest, dest, tag, told.
//  - Reset:
//    - head = tail = count = 0; all valid/complete bits 0; free_slots = ROB_SIZE.
//    - retire_valid, retire_en and rollback are 0.
//  - Dispatch is all-or-nothing:
//    - n = popcount(dispatch_en). If n <= free_slots, write lanes 0..n-1 at
//      tail..tail+n-1 and set tail += n. Otherwise accept none.
//    - Admission is checked against free_slots, which is current-cycle state before
//      retirement, so same-cycle retires do not make room.
//    - The accepted entry has valid=1, complete=0.
//    - dispatch_idx is combinational from tail and is valid even when the group is rejected.
//  - Completion: at the clock edge, set complete (and mispredict) on entry complete_idx.
//    - Ignored if that entry is not valid.
//    - One-cycle minimum completion-to-retire latency; there is no same-cycle bypass.
//  - Retire (combinational from registered state):
//    - Lane h retires iff entry head+h is valid and complete, and all lanes < h retire,
//      and no lane < h retires a mispredicted entry.
//    - head += number retired; count updated with dispatch and retire in the same cycle.
//  - Rollback:
//    - rollback=1 in the cycle a mispredicted entry retires (that entry does commit).
//    - Next cycle: head = tail = count = 0 and every entry is invalid.
//    - Dispatch and completion in the rollback cycle are discarded.
//  - Boundaries:
//    - Full (count = ROB_SIZE): free_slots = 0; any dispatch group is rejected.
//    - Empty: no retire; a completion aimed at the empty buffer is ignored.
//    - Index wrap: ROB_SIZE-1 -> 0 for both head and tail.
//    - Reset asserted mid-operation overrides dispatch, completion and retirement in
//      that cycle.
// CONFIGURATION
//  ROB_PERF_CNT_EN
//  - Defined: adds output retired_count [31:0].
//    - +popcount(retire_valid) each cycle; wraps mod 2^32; cleared to 0 on reset.
//  - Undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING (W=2, ROB_SIZE=8)
//  1. Reset, then idle.
//     -> free_slots=8, retire_valid=00, rollback=0, dispatch_idx={1,0}.
//  2. Dispatch 2 (dest r3/r5, tag 40/41, told 3/5); next cycle complete both.
//     -> next cycle retire_en=11, P_value={41,40}, retire_told={5,3}, free_slots=8.
//  3. Complete idx1 only, idx0 pending.
//     -> retire_valid=00. Complete idx0.
//     -> next cycle retire_valid=11 (in-order stall then release).
//  4. Fill to 7, then dispatch 2.
//     -> rejected, free_slots stays 1, tail unchanged. Dispatch 1.
//     -> free_slots=0, tail wraps to 0.
//  5. Entry 0 is a mispredicted branch, entry 1 is complete.
//     -> retire_valid=01, rollback=1; next cycle free_slots=8, head=tail=0.
//  6. Instr with has_dest=0 completes.
//     -> retire_valid=1, retire_en=0, head advances. With ROB_PERF_CNT_EN,
//        retired_count counts it.

Source files
------------

// File: rtl/ss_rob_retire.sv
// In-order reorder buffer: all-or-nothing group dispatch, CDB completion, in-order
// retirement of up to WIDTH entries per cycle, rollback on a retiring mispredict.
// Optional retirement counter: define ROB_PERF_CNT_EN.
`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif

module ss_rob_retire #(
  parameter int ROB_SIZE = 32,
  localparam int W  = `WIDTH,
  localparam int IW = $clog2(ROB_SIZE),
  localparam int RW = $clog2(`RF_SIZE),
  localparam int PW = $clog2(`PRF_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]    dispatch_en,
  input  logic [W-1:0]    dispatch_has_dest,
  input  logic [W*RW-1:0] dispatch_dest,
  input  logic [W*PW-1:0] dispatch_tag,
  input  logic [W*PW-1:0] dispatch_told,
  output logic [W*IW-1:0] dispatch_idx,
  output logic [IW:0]     free_slots,
  input  logic [W-1:0]    complete_en,
  input  logic [W*IW-1:0] complete_idx,
  input  logic [W-1:0]    complete_mispredict,
  output logic [W-1:0]    retire_valid,
  output logic [W-1:0]    retire_en,
  output logic [W*RW-1:0] retire_dest,
  output logic [W*PW-1:0] P_value,
  output logic [W*PW-1:0] retire_told,
  output logic            rollback
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]     retired_count
`endif
);

  localparam logic [IW:0] SIZE_V = (IW+1)'(ROB_SIZE);

  logic [IW-1:0]       head, tail;
  logic [IW:0]         count;
  logic [ROB_SIZE-1:0] ent_valid, ent_complete, ent_mp, ent_hd;
  logic [RW-1:0]       ent_dest [ROB_SIZE];
  logic [PW-1:0]       ent_tag  [ROB_SIZE];
  logic [PW-1:0]       ent_told [ROB_SIZE];

  logic [IW-1:0] ridx [W];
  logic [IW:0]   n_disp, n_ret;
  logic          accept, blocked;

  assign free_slots = SIZE_V - count;

  // Admission uses pre-retire occupancy, so same-cycle retires never make room.
  always_comb begin
    n_disp = '0;
    dispatch_idx = '0;
    for (int h = 0; h < W; h++) begin
      n_disp = n_disp + {{IW{1'b0}}, dispatch_en[h]};
      dispatch_idx[h*IW +: IW] = tail + IW'(h);
    end
    accept = (n_disp <= free_slots);
  end

  // A lane retires only if every older lane retired and none of them was a mispredict.
  always_comb begin
    retire_valid = '0;
    retire_en    = '0;
    retire_dest  = '0;
    P_value      = '0;
    retire_told  = '0;
    rollback     = 1'b0;
    n_ret        = '0;
    blocked      = 1'b0;
    for (int h = 0; h < W; h++) begin
      ridx[h] = head + IW'(h);
      if (!blocked && ent_valid[ridx[h]] && ent_complete[ridx[h]]) begin
        retire_valid[h]          = 1'b1;
        retire_en[h]             = ent_hd[ridx[h]];
        retire_dest[h*RW +: RW]  = ent_dest[ridx[h]];
        P_value[h*PW +: PW]      = ent_tag[ridx[h]];
        retire_told[h*PW +: PW]  = ent_told[ridx[h]];
        n_ret = n_ret + 1'b1;
        if (ent_mp[ridx[h]]) begin
          rollback = 1'b1;
          blocked  = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || rollback) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_valid    <= '0;
      ent_complete <= '0;
      ent_mp       <= '0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (complete_en[c] && ent_valid[complete_idx[c*IW +: IW]]) begin
          ent_complete[complete_idx[c*IW +: IW]] <= 1'b1;
          ent_mp[complete_idx[c*IW +: IW]]       <= complete_mispredict[c];
        end
      end
      for (int h = 0; h < W; h++) begin
        if (retire_valid[h]) begin
          ent_valid[ridx[h]]    <= 1'b0;
          ent_complete[ridx[h]] <= 1'b0;
        end
      end
      if (accept) begin
        for (int h = 0; h < W; h++) begin
          if ((IW+1)'(h) < n_disp) begin
            ent_valid[tail + IW'(h)]    <= 1'b1;
            ent_complete[tail + IW'(h)] <= 1'b0;
            ent_mp[tail + IW'(h)]       <= 1'b0;
            ent_hd[tail + IW'(h)]       <= dispatch_has_dest[h];
            ent_dest[tail + IW'(h)]     <= dispatch_dest[h*RW +: RW];
            ent_tag[tail + IW'(h)]      <= dispatch_tag[h*PW +: PW];
            ent_told[tail + IW'(h)]     <= dispatch_told[h*PW +: PW];
          end
        end
      end
      head  <= head + n_ret[IW-1:0];
      tail  <= tail + (accept ? n_disp[IW-1:0] : '0);
      count <= count + (accept ? n_disp : '0) - n_ret;
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) retired_count <= '0;
    else       retired_count <= retired_count + 32'(n_ret);
  end
`endif

endmodule

// File: tb/tb_ss_rob_retire.sv
// Bench for ss_rob_retire (WIDTH=2, ROB_SIZE=8): directed scenarios then random traffic,
// checked against an ordered-queue model of the buffer contents.
module tb_ss_rob_retire;
  localparam int W = 2, RW = 5, PW = 6, IW = 3, RS = 8;

  logic            clock = 1'b0, reset;
  logic [W-1:0]    dispatch_en, dispatch_has_dest;
  logic [W*RW-1:0] dispatch_dest;
  logic [W*PW-1:0] dispatch_tag, dispatch_told;
  logic [W*IW-1:0] dispatch_idx;
  logic [IW:0]     free_slots;
  logic [W-1:0]    complete_en, complete_mispredict;
  logic [W*IW-1:0] complete_idx;
  logic [W-1:0]    retire_valid, retire_en;
  logic [W*RW-1:0] retire_dest;
  logic [W*PW-1:0] P_value, retire_told;
  logic            rollback;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]     retired_count;
`endif

  ss_rob_retire #(.ROB_SIZE(RS)) dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_has_dest(dispatch_has_dest),
    .dispatch_dest(dispatch_dest), .dispatch_tag(dispatch_tag),
    .dispatch_told(dispatch_told), .dispatch_idx(dispatch_idx),
    .free_slots(free_slots), .complete_en(complete_en),
    .complete_idx(complete_idx), .complete_mispredict(complete_mispredict),
    .retire_valid(retire_valid), .retire_en(retire_en),
    .retire_dest(retire_dest), .P_value(P_value),
    .retire_told(retire_told), .rollback(rollback)
`ifdef ROB_PERF_CNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit complete; bit mp; bit hd;
    logic [RW-1:0] dest; logic [PW-1:0] tag; logic [PW-1:0] told;
    int idx;
  } ent_t;

  ent_t exp_q[$];
  int head_m = 0;
  longint exp_cnt = 0;
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dispatch_en = '0; dispatch_has_dest = '0; dispatch_dest = '0;
    dispatch_tag = '0; dispatch_told = '0;
    complete_en = '0; complete_idx = '0; complete_mispredict = '0;
  endtask

  task automatic set_lane(input int h, input bit hd, input int d, input int t, input int o);
    dispatch_en[h] = 1'b1;
    dispatch_has_dest[h] = hd;
    dispatch_dest[h*RW +: RW] = RW'(d);
    dispatch_tag[h*PW +: PW] = PW'(t);
    dispatch_told[h*PW +: PW] = PW'(o);
  endtask

  task automatic set_rand_disp(input int n);
    for (int h = 0; h < n; h++)
      set_lane(h, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 63),
               $urandom_range(0, 63));
  endtask

  task automatic set_comp(input int c, input int idx, input bit mp);
    complete_en[c] = 1'b1;
    complete_idx[c*IW +: IW] = IW'(idx);
    complete_mispredict[c] = mp;
  endtask

  // Compare outputs against the model, clock once, then advance the model.
  task automatic step();
    int sz, tl, free, nret, n;
    bit blocked, rb;
    logic [W-1:0] ev, een;
    sz = exp_q.size();
    tl = (head_m + sz) % RS;
    free = RS - sz;
    nret = 0; blocked = 0; rb = 0; ev = '0; een = '0;
    for (int h = 0; h < W; h++) begin
      if (!blocked && h < sz && exp_q[h].complete) begin
        ev[h] = 1'b1; een[h] = exp_q[h].hd; nret++;
        if (exp_q[h].mp) begin rb = 1; blocked = 1; end
      end else blocked = 1;
    end
    check("free_slots", 64'(free_slots), 64'(free));
    check("dispatch_idx", 64'(dispatch_idx), 64'({3'((tl + 1) % RS), 3'(tl)}));
    check("retire_valid", 64'(retire_valid), 64'(ev));
    check("retire_en", 64'(retire_en), 64'(een));
    check("rollback", 64'(rollback), 64'(rb));
    for (int h = 0; h < W; h++) begin
      if (ev[h]) begin
        check("retire_dest", 64'(retire_dest[h*RW +: RW]), 64'(exp_q[h].dest));
        check("P_value", 64'(P_value[h*PW +: PW]), 64'(exp_q[h].tag));
      end
      if (een[h]) check("retire_told", 64'(retire_told[h*PW +: PW]), 64'(exp_q[h].told));
    end
`ifdef ROB_PERF_CNT_EN
    check("retired_count", 64'(retired_count), 64'(exp_cnt[31:0]));
`endif
    @(posedge clock);
    exp_cnt = exp_cnt + nret;
    if (reset || rb) begin
      exp_q.delete();
      head_m = 0;
      if (reset) exp_cnt = 0;
    end else begin
      for (int c = 0; c < W; c++)
        if (complete_en[c])
          foreach (exp_q[i])
            if (exp_q[i].idx == int'(complete_idx[c*IW +: IW])) begin
              exp_q[i].complete = 1;
              exp_q[i].mp = complete_mispredict[c];
            end
      for (int k = 0; k < nret; k++) void'(exp_q.pop_front());
      head_m = (head_m + nret) % RS;
      n = $countones(dispatch_en);
      if (n <= free)
        for (int h = 0; h < n; h++) begin
          ent_t e;
          e.complete = 0; e.mp = 0; e.hd = dispatch_has_dest[h];
          e.dest = dispatch_dest[h*RW +: RW];
          e.tag = dispatch_tag[h*PW +: PW];
          e.told = dispatch_told[h*PW +: PW];
          e.idx = (tl + h) % RS;
          exp_q.push_back(e);
        end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    exp_q.delete(); head_m = 0; exp_cnt = 0;
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int c;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      clear_inputs();
      c = 0;
      foreach (exp_q[i])
        if (!exp_q[i].complete && c < W) begin set_comp(c, exp_q[i].idx, 0); c++; end
      step();
    end
    clear_inputs();
    check("drain_free_slots", 64'(free_slots), 64'(RS));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: reset then idle
    check("reset_free_slots", 64'(free_slots), 64'(8));
    check("reset_retire_valid", 64'(retire_valid), 64'(0));
    check("reset_rollback", 64'(rollback), 64'(0));
    check("reset_dispatch_idx", 64'(dispatch_idx), 64'({3'd1, 3'd0}));
    step();

    // 2: dispatch two, complete both, retire both
    set_lane(0, 1, 3, 40, 3); set_lane(1, 1, 5, 41, 5);
    step();
    clear_inputs(); set_comp(0, 0, 0); set_comp(1, 1, 0);
    step();
    clear_inputs();
    check("t2_retire_en", 64'(retire_en), 64'(2'b11));
    check("t2_P_value", 64'(P_value), 64'({6'd41, 6'd40}));
    check("t2_retire_told", 64'(retire_told), 64'({6'd5, 6'd3}));
    step();
    check("t2_free_slots", 64'(free_slots), 64'(8));

    // 3: in-order stall, then release
    do_reset();
    set_rand_disp(2);
    step();
    clear_inputs(); set_comp(0, 1, 0);
    step();
    clear_inputs();
    check("t3_stall", 64'(retire_valid), 64'(0));
    set_comp(0, 0, 0);
    step();
    clear_inputs();
    check("t3_release", 64'(retire_valid), 64'(2'b11));
    step();

    // 4: fill to 7, rejected group, last slot, full
    do_reset();
    for (int k = 0; k < 3; k++) begin clear_inputs(); set_rand_disp(2); step(); end
    clear_inputs(); set_rand_disp(1); step();
    check("t4_free_7", 64'(free_slots), 64'(1));
    clear_inputs(); set_rand_disp(2); step();
    check("t4_rejected_free", 64'(free_slots), 64'(1));
    check("t4_rejected_tail", 64'(dispatch_idx[2:0]), 64'(7));
    clear_inputs(); set_rand_disp(1); step();
    check("t4_full_free", 64'(free_slots), 64'(0));
    check("t4_tail_wrap", 64'(dispatch_idx[2:0]), 64'(0));
    clear_inputs(); set_rand_disp(2); step();
    drain();

    // 5: mispredicted branch at head triggers rollback
    do_reset();
    set_rand_disp(2);
    step();
    clear_inputs(); set_comp(0, 0, 1); set_comp(1, 1, 0);
    step();
    clear_inputs(); set_rand_disp(2); set_comp(0, 1, 0);
    check("t5_retire_valid", 64'(retire_valid), 64'(2'b01));
    check("t5_rollback", 64'(rollback), 64'(1));
    step();
    clear_inputs();
    check("t5_free_after", 64'(free_slots), 64'(8));
    check("t5_tail_after", 64'(dispatch_idx[2:0]), 64'(0));

    // 6: no-dest instruction retires without an RRAT write
    set_lane(0, 0, 7, 12, 9);
    step();
    clear_inputs(); set_comp(0, 0, 0);
    step();
    clear_inputs();
    check("t6_retire_valid", 64'(retire_valid[0]), 64'(1));
    check("t6_retire_en", 64'(retire_en[0]), 64'(0));
    step();
    check("t6_head_adv", 64'(free_slots), 64'(8));

    // random traffic, with one reset in the middle of live activity
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      set_rand_disp($urandom_range(0, 2));
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 1) == 1) begin
          if (exp_q.size() > 0 && $urandom_range(0, 7) != 0)
            set_comp(c, exp_q[$urandom_range(0, exp_q.size() - 1)].idx,
                     ($urandom_range(0, 15) == 0));
          else
            set_comp(c, $urandom_range(0, RS - 1), 0);
        end
      if (cyc == 200) begin
        do_reset();
        clear_inputs();
        check("mid_reset_free", 64'(free_slots), 64'(8));
        check("mid_reset_retire", 64'(retire_valid), 64'(0));
      end else begin
        step();
      end
    end
    clear_inputs();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
